// File: rtl/uart_cmd_assembler_pkg.sv
// Shared definitions for the UART command assembler: FSM states and frame geometry.
// No logic, so it adds no latency.
// No backpressure of its own.
package uart_cmd_assembler_pkg;

    localparam int FRAME_W      = 9;
    localparam int CLKS_PER_BIT = 32;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_DHI  = 2'd1,
        S_DLO  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_cmd_assembler_frame_parity_chk.sv
// Parity check of one received frame (data byte plus parity bit).
// Combinational, zero latency.
// No backpressure; the result is valid whenever the frame input is.
module frame_parity_chk
    import uart_cmd_assembler_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [FRAME_W-1:0] frame_i,
    output logic               ok_o
);

    // The XOR over all nine bits equals PARITY_ODD for a good frame.
    assign ok_o = ((^frame_i) == PARITY_ODD);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Groups three parity-good UART bytes into an {addr, data_hi, data_lo} register-write command.
// Latency: cmd_valid rises 1 clk after the third frame strobe; error pulses appear 1 clk after the strobe.
// Backpressure: the command is held until cmd_ready; frames arriving meanwhile are dropped with overrun_err.
// Build option: define CMD_TIMEOUT_EN to abandon a partial command after TIMEOUT_CYC idle cycles.
module uart_cmd_assembler
    import uart_cmd_assembler_pkg::*;
#(
    parameter bit          PARITY_ODD  = 1'b0,
    parameter logic [31:0] TIMEOUT_CYC = 32'd3200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [7:0]         cmd_addr,
    output logic [15:0]        cmd_data,
    output logic               parity_err,
    output logic               overrun_err
);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic        perr_q, perr_d;
    logic        oerr_q, oerr_d;
    logic        ign_q;
    logic        frame_ok;
    logic        fv;
    logic        timeout_hit;

    frame_parity_chk #(
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .frame_i (frame),
        .ok_o    (frame_ok)
    );

    // A strobe landing on the first edge after reset release is discarded.
    assign fv = frame_valid & ~ign_q;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;

    // Inter-byte gap timer: runs only while a command is partially assembled.
    always_comb begin
        timeout_hit = ((state_q == S_DHI) || (state_q == S_DLO)) &&
                      (timer_q == TIMEOUT_CYC - 32'd1);
        timer_d = timer_q + 32'd1;
        if (fv || timeout_hit || !((state_q == S_DHI) || (state_q == S_DLO))) begin
            timer_d = '0;
        end
    end

    // Gap timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
`endif

    // Next-state, byte latching and error-pulse decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        vld_d   = vld_q;
        perr_d  = 1'b0;
        oerr_d  = 1'b0;
        if (state_q == S_OUT) begin
            // Held command: any new frame is dropped unchecked, the handshake still completes.
            if (fv) begin
                oerr_d = 1'b1;
            end
            if (cmd_ready) begin
                vld_d   = 1'b0;
                state_d = S_ADDR;
            end
        end else if (fv) begin
            if (!frame_ok) begin
                perr_d  = 1'b1;
                state_d = S_ADDR;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        addr_d  = frame[7:0];
                        state_d = S_DHI;
                    end
                    S_DHI: begin
                        data_d[15:8] = frame[7:0];
                        state_d      = S_DLO;
                    end
                    default: begin
                        data_d[7:0] = frame[7:0];
                        vld_d       = 1'b1;
                        state_d     = S_OUT;
                    end
                endcase
            end
        end else if (timeout_hit) begin
            state_d = S_ADDR;
        end
    end

    // State, command and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ADDR;
            addr_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            perr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            perr_q  <= perr_d;
            oerr_q  <= oerr_d;
            ign_q   <= 1'b0;
        end
    end

    assign cmd_valid   = vld_q;
    assign cmd_addr    = addr_q;
    assign cmd_data    = data_q;
    assign parity_err  = perr_q;
    assign overrun_err = oerr_q;

endmodule
